// File: rtl/ddr2_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module   : ddr2_cmd_sched
// Brief    : Closed-page DDR2 x16 sequencer, one request at a time as
//            ACTIVATE -> READ/WRITE -> PRECHARGE with counter-timed gaps.
// Revision : 1.0  initial release
// ============================================================================
module ddr2_cmd_sched #(
  parameter int T_RCD  = 3,
  parameter int T_RP   = 3,
  parameter int T_WR   = 3,
  parameter int WL     = 2,
  parameter int RD_LAT = 8,
  parameter int BURST  = 4
) (
  input  logic        ck,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_bank,
  input  logic [12:0] req_row,
  input  logic [9:0]  req_col,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        cke,
  output logic        cs_n,
  output logic        ras_n,
  output logic        cas_n,
  output logic        we_n,
  output logic [1:0]  ba,
  output logic [12:0] addr,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic [1:0]  dqs_out,
  output logic        dqs_oe,
  input  logic [15:0] dq_in
);

  generate
    if (T_RCD < 1 || T_RCD > 15 || T_RP < 1 || T_RP > 15 || T_WR < 1 || T_WR > 15 ||
        WL < 1 || WL > 15 || RD_LAT < 1 || RD_LAT > 15 || BURST < 1 || BURST > 15) begin : g_param_check
      $error("ddr2_cmd_sched: timing parameters must lie in 1..15");
    end
  endgenerate

  localparam logic [3:0] C_CMD_DES = 4'b1111;
  localparam logic [3:0] C_CMD_NOP = 4'b0111;
  localparam logic [3:0] C_CMD_ACT = 4'b0011;
  localparam logic [3:0] C_CMD_RD  = 4'b0101;
  localparam logic [3:0] C_CMD_WR  = 4'b0100;
  localparam logic [3:0] C_CMD_PRE = 4'b0010;

  localparam logic [3:0] C_INIT_LD = 4'd2;
  localparam logic [3:0] C_TRCD_LD = 4'(T_RCD - 1);
  localparam logic [3:0] C_WL_LD   = 4'(WL);
  localparam logic [3:0] C_TWR_LD  = 4'(T_WR);
  localparam logic [3:0] C_RD_LD   = 4'(RD_LAT);
  localparam logic [3:0] C_BUS_LD  = 4'(BURST - 1);
  localparam logic [3:0] C_TRP_LD  = 4'(T_RP);

  typedef enum logic [3:0] {
    S_INIT    = 4'd0,
    S_IDLE    = 4'd1,
    S_ACT     = 4'd2,
    S_TRCD    = 4'd3,
    S_RW      = 4'd4,
    S_WR_PRE  = 4'd5,
    S_WR_DATA = 4'd6,
    S_WR_POST = 4'd7,
    S_TWR     = 4'd8,
    S_RD_WAIT = 4'd9,
    S_RD_BUS  = 4'd10,
    S_PRE     = 4'd11,
    S_TRP     = 4'd12
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        w_last;
  logic        w_rd_capture;
  logic        r_write;
  logic [1:0]  r_bank;
  logic [9:0]  r_col;
  logic [15:0] r_wdata;
  logic [15:0] r_dq_neg;
  logic [3:0]  w_cmd;
  logic [1:0]  w_ba;
  logic [12:0] w_addr;

  // Wait states hold the remaining cycle count including the current one.
  assign w_last       = (r_cnt == 4'd1);
  assign w_rd_capture = (r_state == S_RD_WAIT) && w_last;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = (r_cnt != 4'd0) ? r_cnt - 4'd1 : 4'd0;
    case (r_state)
      S_INIT:    if (r_cnt == 4'd0) w_state_nxt = S_IDLE;
      S_IDLE:    if (req_valid) w_state_nxt = S_ACT;
      S_ACT: begin
        if (T_RCD > 1) begin
          w_state_nxt = S_TRCD;
          w_cnt_nxt   = C_TRCD_LD;
        end else begin
          w_state_nxt = S_RW;
        end
      end
      S_TRCD:    if (w_last) w_state_nxt = S_RW;
      S_RW: begin
        w_state_nxt = r_write ? S_WR_PRE : S_RD_WAIT;
        w_cnt_nxt   = r_write ? C_WL_LD : C_RD_LD;
      end
      S_WR_PRE:  if (w_last) w_state_nxt = S_WR_DATA;
      S_WR_DATA: w_state_nxt = S_WR_POST;
      S_WR_POST: begin
        w_state_nxt = S_TWR;
        w_cnt_nxt   = C_TWR_LD;
      end
      S_TWR:     if (w_last) w_state_nxt = S_PRE;
      S_RD_WAIT: begin
        if (w_last) begin
          w_state_nxt = (BURST > 1) ? S_RD_BUS : S_PRE;
          w_cnt_nxt   = C_BUS_LD;
        end
      end
      S_RD_BUS:  if (w_last) w_state_nxt = S_PRE;
      S_PRE: begin
        w_state_nxt = S_TRP;
        w_cnt_nxt   = C_TRP_LD;
      end
      S_TRP:     if (w_last) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_INIT;
    endcase

    // Pads are registered, so they are decoded from the state being entered.
    w_cmd  = C_CMD_NOP;
    w_ba   = ba;
    w_addr = addr;
    case (w_state_nxt)
      S_INIT: w_cmd = C_CMD_DES;
      S_ACT: begin
        w_cmd  = C_CMD_ACT;
        w_ba   = req_bank;
        w_addr = req_row;
      end
      S_RW: begin
        w_cmd  = r_write ? C_CMD_WR : C_CMD_RD;
        w_ba   = r_bank;
        w_addr = {3'b000, r_col};
      end
      S_PRE: begin
        w_cmd  = C_CMD_PRE;
        w_ba   = r_bank;
        w_addr = 13'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      r_state   <= S_INIT;
      r_cnt     <= C_INIT_LD;
      r_write   <= 1'b0;
      r_bank    <= 2'd0;
      r_col     <= 10'd0;
      r_wdata   <= 16'd0;
      cke       <= 1'b0;
      {cs_n, ras_n, cas_n, we_n} <= C_CMD_DES;
      ba        <= 2'd0;
      addr      <= 13'd0;
      req_ready <= 1'b0;
      dq_oe     <= 1'b0;
      dqs_oe    <= 1'b0;
      dq_out    <= 16'd0;
      dqs_out   <= 2'b00;
      rsp_valid <= 1'b0;
      rsp_rdata <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if ((r_state == S_IDLE) && req_valid) begin
        r_write <= req_write;
        r_bank  <= req_bank;
        r_col   <= req_col;
        r_wdata <= req_wdata;
      end
      cke       <= 1'b1;
      {cs_n, ras_n, cas_n, we_n} <= w_cmd;
      ba        <= w_ba;
      addr      <= w_addr;
      req_ready <= (w_state_nxt == S_IDLE);
      dqs_oe    <= (w_state_nxt == S_WR_PRE) || (w_state_nxt == S_WR_DATA) ||
                   (w_state_nxt == S_WR_POST);
      dqs_out   <= (w_state_nxt == S_WR_DATA) ? 2'b11 : 2'b00;
      dq_oe     <= (w_state_nxt == S_WR_DATA) || (w_state_nxt == S_WR_POST);
      if (w_state_nxt == S_WR_DATA) dq_out <= r_wdata;
      rsp_valid <= w_rd_capture;
      if (w_rd_capture) rsp_rdata <= r_dq_neg;
    end
  end

  // First read beat is centred on the falling edge of the last RD_WAIT cycle.
  always_ff @(negedge ck or posedge reset) begin
    if (reset) begin
      r_dq_neg <= 16'd0;
    end else if (w_rd_capture) begin
      r_dq_neg <= dq_in;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ddr2_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr2_cmd_sched
// Brief    : Random request traffic, device memory model on the pins and a
//            cycle timeline model of the expected command/strobe sequence.
// Revision : 1.0  initial release
// ============================================================================
module tb_ddr2_cmd_sched;

  localparam int T_RCD  = 3;
  localparam int T_RP   = 3;
  localparam int T_WR   = 3;
  localparam int WL     = 2;
  localparam int RD_LAT = 8;
  localparam int BURST  = 4;

  logic        ck = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_bank = '0;
  logic [12:0] req_row = '0;
  logic [9:0]  req_col = '0;
  logic [15:0] req_wdata = '0;
  logic [15:0] dq_in = '0;
  logic        req_ready, rsp_valid, cke, cs_n, ras_n, cas_n, we_n, dq_oe, dqs_oe;
  logic [15:0] rsp_rdata, dq_out;
  logic [1:0]  ba, dqs_out;
  logic [12:0] addr;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc;

  ddr2_cmd_sched #(
    .T_RCD(T_RCD), .T_RP(T_RP), .T_WR(T_WR), .WL(WL), .RD_LAT(RD_LAT), .BURST(BURST)
  ) dut (
    .ck(ck), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_bank(req_bank), .req_row(req_row), .req_col(req_col), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .ba(ba), .addr(addr),
    .dq_out(dq_out), .dq_oe(dq_oe), .dqs_out(dqs_out), .dqs_oe(dqs_oe), .dq_in(dq_in)
  );

  always #5 ck = ~ck;

  // Cycle 0 is the period in which reset is released.
  always @(posedge ck or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int key(input logic [1:0] b, input logic [12:0] r, input logic [9:0] c);
    return int'({7'b0, b, r, c});
  endfunction

  // ---------------- device model ----------------
  logic [12:0] dev_open_row [4];
  logic [15:0] dev_mem [int];
  logic [1:0]  dev_wr_bank = '0;
  logic [9:0]  dev_wr_col = '0;
  bit          dev_rd_pend = 1'b0;
  int          dev_rd_due = 0;
  logic [15:0] dev_rd_data = '0;

  always @(negedge ck) begin : dev_cmd
    int k;
    if (reset) begin
      dev_rd_pend = 1'b0;
    end else begin
      case ({cs_n, ras_n, cas_n, we_n})
        4'b0011: dev_open_row[ba] = addr;
        4'b0100: begin dev_wr_bank = ba; dev_wr_col = addr[9:0]; end
        4'b0101: begin
          k = key(ba, dev_open_row[ba], addr[9:0]);
          dev_rd_pend = 1'b1;
          dev_rd_due  = cyc + RD_LAT;
          dev_rd_data = dev_mem.exists(k) ? dev_mem[k] : 16'($urandom);
        end
        default: ;
      endcase
      if (dqs_oe && dq_oe && dqs_out == 2'b11)
        dev_mem[key(dev_wr_bank, dev_open_row[dev_wr_bank], dev_wr_col)] = dq_out;
    end
  end

  // Only the due cycle carries the stored word; every other cycle is noise.
  always @(posedge ck) begin
    #1;
    if (dev_rd_pend && cyc == dev_rd_due) dq_in = dev_rd_data;
    else dq_in = 16'($urandom);
  end

  // ---------------- reference timeline + scoreboard ----------------
  typedef struct { int due; logic [15:0] data; bit known; } rsp_t;
  rsp_t        sb_q[$];
  logic [15:0] ref_mem [int];
  bit          in_txn = 1'b0;
  bit          t_write;
  logic [1:0]  t_bank;
  logic [12:0] t_row;
  logic [9:0]  t_col;
  logic [15:0] t_data;
  int          c_act, c_rw, c_pre, c_rdy;

  always @(negedge ck) begin : monitor
    logic [40:0] act_v, exp_v, msk;
    logic        e_cke, e_rdy, e_dqoe, e_dqsoe;
    logic [3:0]  e_cmd;
    logic [1:0]  e_ba, m_ba, e_dqs, m_dqs;
    logic [12:0] e_addr, m_addr;
    logic [15:0] e_dq, m_dq;
    int          rel, k;
    if (reset) begin
      in_txn = 1'b0;
      sb_q.delete();
    end else begin
      if (in_txn && cyc >= c_rdy) in_txn = 1'b0;
      e_cke = (cyc >= 1);
      e_rdy = !in_txn && cyc >= 3;
      e_cmd = (cyc < 3) ? 4'b1111 : 4'b0111;
      e_ba = '0; m_ba = '0; e_addr = '0; m_addr = '0;
      e_dqoe = 1'b0; e_dqsoe = 1'b0; e_dqs = '0; m_dqs = '0; e_dq = '0; m_dq = '0;
      if (in_txn) begin
        if (cyc == c_act) begin
          e_cmd = 4'b0011; e_ba = t_bank; e_addr = t_row; m_ba = '1; m_addr = '1;
        end else if (cyc == c_rw) begin
          e_cmd = t_write ? 4'b0100 : 4'b0101;
          e_ba = t_bank; e_addr = {3'b000, t_col}; m_ba = '1; m_addr = '1;
        end else if (cyc == c_pre) begin
          e_cmd = 4'b0010; e_ba = t_bank; m_ba = '1; m_addr = 13'h0400;
        end
        rel = cyc - c_rw;
        if (t_write && rel >= 1 && rel <= WL + 2) begin
          e_dqsoe = 1'b1; m_dqs = '1;
          if (rel == WL + 1) begin
            e_dqs = 2'b11; e_dqoe = 1'b1; e_dq = t_data; m_dq = '1;
          end
          if (rel == WL + 2) e_dqoe = 1'b1;
        end
      end
      act_v = {cke, cs_n, ras_n, cas_n, we_n, ba, addr, req_ready, dq_oe, dqs_oe, dqs_out, dq_out};
      exp_v = {e_cke, e_cmd, e_ba, e_addr, e_rdy, e_dqoe, e_dqsoe, e_dqs, e_dq};
      msk   = {1'b1, 4'hF, m_ba, m_addr, 1'b1, 1'b1, 1'b1, m_dqs, m_dq};
      check($sformatf("pins@cyc%0d", cyc), 64'(act_v & msk), 64'(exp_v & msk));

      if (sb_q.size() > 0 && cyc == sb_q[0].due) begin
        check("rsp_valid_at_due", 64'(rsp_valid), 64'(1));
        if (rsp_valid && sb_q[0].known) check("rsp_rdata", 64'(rsp_rdata), 64'(sb_q[0].data));
        void'(sb_q.pop_front());
      end else if (rsp_valid) begin
        check("rsp_valid_unexpected", 64'(rsp_valid), 64'(0));
      end

      if (e_rdy && req_valid) begin
        in_txn  = 1'b1;
        t_write = req_write; t_bank = req_bank; t_row = req_row; t_col = req_col; t_data = req_wdata;
        c_act = cyc + 1;
        c_rw  = c_act + T_RCD;
        c_pre = t_write ? c_rw + WL + 3 + T_WR : c_rw + RD_LAT + BURST;
        c_rdy = c_pre + T_RP + 1;
        k = key(t_bank, t_row, t_col);
        if (t_write) ref_mem[k] = t_data;
        else sb_q.push_back('{due: c_rw + RD_LAT + 1,
                              data: ref_mem.exists(k) ? ref_mem[k] : 16'h0,
                              known: ref_mem.exists(k)});
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct { logic [1:0] b; logic [12:0] r; logic [9:0] c; } addr_t;
  addr_t       wlist[$];
  logic [12:0] row_pool [4] = '{13'h0A5, 13'h123, 13'h1F0, 13'h000};
  logic [9:0]  col_pool [4] = '{10'h010, 10'h045, 10'h3FE, 10'h000};

  task automatic scramble_req();
    req_write = 1'($urandom); req_bank = 2'($urandom); req_row = 13'($urandom);
    req_col = 10'($urandom); req_wdata = 16'($urandom);
  endtask

  // Busy cycles optionally present a held-high valid with drifting fields.
  task automatic do_req(input bit w, input logic [1:0] b, input logic [12:0] r,
                        input logic [9:0] c, input logic [15:0] d, input bit jitter);
    for (int i = 0; i < 200; i++) begin
      @(posedge ck); #1;
      if (req_ready) break;
      req_valid = jitter;
      scramble_req();
    end
    check("req_ready_wait", 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_write = w; req_bank = b; req_row = r; req_col = c; req_wdata = d;
    @(posedge ck); #1;
    req_valid = 1'b0;
    scramble_req();
    if (w) wlist.push_back('{b: b, r: r, c: c});
  endtask

  initial begin
    addr_t a;
    bit    w, jit;
    repeat (3) @(posedge ck);
    #1;
    check("rst_cke", 64'(cke), 64'(0));
    check("rst_cmd", 64'({cs_n, ras_n, cas_n, we_n}), 64'(4'b1111));
    check("rst_ready_rsp", 64'({req_ready, rsp_valid}), 64'(0));
    check("rst_oe", 64'({dq_oe, dqs_oe}), 64'(0));
    check("rst_ba_addr", 64'({ba, addr}), 64'(0));
    check("rst_data", 64'({dq_out, dqs_out, rsp_rdata}), 64'(0));
    #1 reset = 1'b0;

    do_req(1'b1, 2'd1, 13'h0A5, 10'h010, 16'hBEEF, 1'b0);
    do_req(1'b0, 2'd1, 13'h0A5, 10'h010, 16'h0000, 1'b0);
    do_req(1'b1, 2'd0, 13'h123, 10'h045, 16'h1111, 1'b1);
    do_req(1'b1, 2'd3, 13'h123, 10'h045, 16'h3333, 1'b1);
    do_req(1'b0, 2'd0, 13'h123, 10'h045, 16'h0000, 1'b1);
    do_req(1'b0, 2'd3, 13'h123, 10'h045, 16'h0000, 1'b1);

    for (int n = 0; n < 24; n++) begin
      w   = ($urandom_range(0, 1) == 1);
      jit = ($urandom_range(0, 1) == 1);
      if (w) begin
        a.b = 2'($urandom_range(0, 3));
        a.r = row_pool[$urandom_range(0, 3)];
        a.c = col_pool[$urandom_range(0, 3)];
        do_req(1'b1, a.b, a.r, a.c, 16'($urandom), jit);
      end else begin
        a = wlist[$urandom_range(0, wlist.size() - 1)];
        do_req(1'b0, a.b, a.r, a.c, 16'($urandom), jit);
      end
    end

    // Abort a write in its data beat; this address is never read back.
    do_req(1'b1, 2'd2, 13'h1FFF, 10'h3FF, 16'hDEAD, 1'b0);
    void'(wlist.pop_back());
    for (int i = 0; i < 50; i++) begin
      @(posedge ck); #2;
      if (dq_oe) break;
    end
    check("wr_data_reached", 64'(dq_oe), 64'(1));
    reset = 1'b1;
    #1;
    check("abort_oe_released", 64'({dq_oe, dqs_oe}), 64'(0));
    check("abort_cs_n", 64'(cs_n), 64'(1));
    check("abort_cke_ready", 64'({cke, req_ready}), 64'(0));
    repeat (3) @(posedge ck);
    #2 reset = 1'b0;

    do_req(1'b1, 2'd2, 13'h0F0, 10'h020, 16'h5A5A, 1'b1);
    do_req(1'b0, 2'd2, 13'h0F0, 10'h020, 16'h0000, 1'b1);

    for (int i = 0; i < 100; i++) begin
      @(posedge ck); #1;
      if (req_ready && sb_q.size() == 0) break;
    end
    check("drain_ready", 64'(req_ready), 64'(1));
    check("drain_scoreboard", 64'(sb_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
